// File: rtl/fetch_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_seq_ctrl_if
// Description : Bundle of pipeline-side signals between the hazard/fetch
//               controller and the datapath (PC register, pipeline regs).
//               master = datapath side, slave = fetch_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_seq_ctrl_if;
  // Datapath -> controller
  logic [31:0] pc_f;
  logic        load_use_d;
  logic        md_use_d;
  logic        md_start_e;
  logic        md_is_div_e;
  logic        br_taken_d;
  logic [31:0] br_target_d;
  logic        eret_d;
  logic [31:0] epc;
  logic        exc_req_m;
  // Controller -> datapath
  logic [31:0] next_pc;
  logic        pc_en;
  logic        stall_fd;
  logic        flush_fd;
  logic        flush_de;
  logic        flush_em;
  logic        md_busy;
  logic [1:0]  state;
  logic [31:0] stall_cnt;

  modport master (
    output pc_f, load_use_d, md_use_d, md_start_e, md_is_div_e,
           br_taken_d, br_target_d, eret_d, epc, exc_req_m,
    input  next_pc, pc_en, stall_fd, flush_fd, flush_de, flush_em,
           md_busy, state, stall_cnt
  );

  modport slave (
    input  pc_f, load_use_d, md_use_d, md_start_e, md_is_div_e,
           br_taken_d, br_target_d, eret_d, epc, exc_req_m,
    output next_pc, pc_en, stall_fd, flush_fd, flush_de, flush_em,
           md_busy, state, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fetch_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_seq_ctrl
// Description : Fetch sequencing and hazard control for the 5-stage pipeline.
//               Picks the next PC (exception > stall > ERET > branch > seq),
//               drives PC enable and IF/ID, ID/EX, EX/MEM freeze/flush, owns
//               the mult/div busy counter and a stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_seq_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_4180,
  parameter int          MULT_CYCLES = 5,
  parameter int          DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  fetch_seq_ctrl_if.slave  bus
);

  localparam logic [3:0] c_MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] c_DIV_LOAD  = 4'(DIV_CYCLES);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_EXC   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_md_cnt;
  logic [3:0]  w_md_cnt_nxt;
  logic [31:0] r_stall_cnt;

  logic        w_md_start;
  logic        w_md_busy;
  logic        w_stall;
  logic [31:0] w_pc_seq;
  logic [31:0] w_next_pc;
  logic        w_pc_en;
  logic        w_stall_fd;
  logic        w_flush_fd;
  logic        w_flush_de;
  logic        w_flush_em;

  // A start from an instruction being cancelled by an exception never counts.
  assign w_md_start = bus.md_start_e & ~bus.exc_req_m;
  // Busy includes the start cycle itself so the very next D instruction stalls.
  assign w_md_busy  = ~reset & ((r_md_cnt != 4'd0) | w_md_start);
  assign w_stall    = bus.load_use_d | (bus.md_use_d & w_md_busy);
  assign w_pc_seq   = bus.pc_f + 32'd4;

  // Next-PC selection and pipeline control, highest-priority event first.
  always_comb begin
    w_next_pc  = w_pc_seq;
    w_pc_en    = 1'b1;
    w_stall_fd = 1'b0;
    w_flush_fd = 1'b0;
    w_flush_de = 1'b0;
    w_flush_em = 1'b0;
    if (reset) begin
      // Hold everything quiet; the PC register resets itself.
      w_next_pc = w_pc_seq;
    end else if (bus.exc_req_m) begin
      w_next_pc  = EXC_VECTOR;
      w_flush_fd = 1'b1;
      w_flush_de = 1'b1;
      w_flush_em = 1'b1;
    end else if (w_stall) begin
      // Redirects in D stay frozen there and are taken once the stall clears.
      w_pc_en    = 1'b0;
      w_stall_fd = 1'b1;
      w_flush_de = 1'b1;
    end else if (bus.eret_d) begin
      // ERET has no delay slot: kill the instruction already fetched.
      w_next_pc  = bus.epc;
      w_flush_fd = 1'b1;
    end else if (bus.br_taken_d) begin
      // Delay slot is already in F and executes normally.
      w_next_pc  = bus.br_target_d;
    end
  end

  // Mult/div counter next value: reload on start, else count down to zero.
  always_comb begin
    w_md_cnt_nxt = r_md_cnt;
    if (w_md_start) begin
      w_md_cnt_nxt = bus.md_is_div_e ? c_DIV_LOAD : c_MULT_LOAD;
    end else if (r_md_cnt != 4'd0) begin
      w_md_cnt_nxt = r_md_cnt - 4'd1;
    end
  end

  // Mult/div counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_cnt <= 4'd0;
    end else begin
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  // Observational FSM next state: exception, then stall, else run.
  always_comb begin
    w_state_nxt = ST_RUN;
    if (bus.exc_req_m) begin
      w_state_nxt = ST_EXC;
    end else if (w_stall) begin
      w_state_nxt = ST_STALL;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Count frozen-PC cycles, saturating at all ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= 32'd0;
    end else if (!w_pc_en && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.next_pc   = w_next_pc;
  assign bus.pc_en     = w_pc_en;
  assign bus.stall_fd  = w_stall_fd;
  assign bus.flush_fd  = w_flush_fd;
  assign bus.flush_de  = w_flush_de;
  assign bus.flush_em  = w_flush_em;
  assign bus.md_busy   = w_md_busy;
  assign bus.state     = r_state;
  assign bus.stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_seq_ctrl
// Description : Self-checking bench for fetch_seq_ctrl: directed scenarios
//               with literal expectations plus a randomized run compared
//               every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_seq_ctrl;

  localparam logic [31:0] c_EXC = 32'h0000_4180;
  localparam int          c_MUL = 5;
  localparam int          c_DIV = 10;

  logic clk = 1'b0;
  logic reset;

  fetch_seq_ctrl_if bus ();

  fetch_seq_ctrl #(
    .EXC_VECTOR  (c_EXC),
    .MULT_CYCLES (c_MUL),
    .DIV_CYCLES  (c_DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The unit is busy through cycle number busy_until (inclusive).
  longint cyc        = 0;
  longint busy_until = -1;
  longint scnt_m     = 0;
  int     st_m       = 0;

  logic        e_start, e_busy, e_stall, e_en, e_sfd, e_ffd, e_fde, e_fem;
  logic [31:0] e_pc;

  // Compare every cycle at the falling edge, then advance the model.
  always @(negedge clk) begin
    e_pc  = bus.pc_f + 32'd4;
    e_en  = 1'b1;
    e_sfd = 1'b0; e_ffd = 1'b0; e_fde = 1'b0; e_fem = 1'b0;
    e_start = 1'b0; e_busy = 1'b0; e_stall = 1'b0;
    if (!reset) begin
      e_start = bus.md_start_e && !bus.exc_req_m;
      e_busy  = (cyc <= busy_until) || e_start;
      e_stall = bus.load_use_d || (bus.md_use_d && e_busy);
      if (bus.exc_req_m) begin
        e_pc = c_EXC; e_ffd = 1'b1; e_fde = 1'b1; e_fem = 1'b1;
      end else if (e_stall) begin
        e_en = 1'b0; e_sfd = 1'b1; e_fde = 1'b1;
      end else if (bus.eret_d) begin
        e_pc = bus.epc; e_ffd = 1'b1;
      end else if (bus.br_taken_d) begin
        e_pc = bus.br_target_d;
      end
    end
    if (e_en) chk("m_next_pc", bus.next_pc, e_pc);
    chk("m_pc_en",     32'(bus.pc_en),    32'(e_en));
    chk("m_stall_fd",  32'(bus.stall_fd), 32'(e_sfd));
    chk("m_flush_fd",  32'(bus.flush_fd), 32'(e_ffd));
    chk("m_flush_de",  32'(bus.flush_de), 32'(e_fde));
    chk("m_flush_em",  32'(bus.flush_em), 32'(e_fem));
    if (!reset) chk("m_md_busy", 32'(bus.md_busy), 32'(e_busy));
    chk("m_state",     32'(bus.state),    32'(st_m));
    chk("m_stall_cnt", bus.stall_cnt,     32'(scnt_m));
    if (reset) begin
      busy_until = -1;
      scnt_m     = 0;
      st_m       = 0;
    end else begin
      if (e_start) busy_until = cyc + (bus.md_is_div_e ? c_DIV : c_MUL);
      if (!e_en && scnt_m < 64'h0000_0000_FFFF_FFFF) scnt_m++;
      st_m = bus.exc_req_m ? 2 : (e_stall ? 1 : 0);
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #3;
  endtask

  task automatic idle();
    bus.load_use_d  = 1'b0;
    bus.md_use_d    = 1'b0;
    bus.md_start_e  = 1'b0;
    bus.md_is_div_e = 1'b0;
    bus.br_taken_d  = 1'b0;
    bus.br_target_d = 32'h0000_0000;
    bus.eret_d      = 1'b0;
    bus.epc         = 32'h0000_0000;
    bus.exc_req_m   = 1'b0;
  endtask

  task automatic md_stall_run(input logic is_div, input int n, input logic [31:0] cnt_after, input string tag);
    step();
    bus.md_start_e = 1'b1; bus.md_is_div_e = is_div; bus.md_use_d = 1'b1;
    for (int k = 0; k <= n; k++) begin
      if (k == 1) bus.md_start_e = 1'b0;
      look();
      if (k < n) begin
        chk({tag, "_pc_en"},    32'(bus.pc_en),    32'd0);
        chk({tag, "_stall_fd"}, 32'(bus.stall_fd), 32'd1);
        chk({tag, "_flush_de"}, 32'(bus.flush_de), 32'd1);
      end else begin
        chk({tag, "_release"},  32'(bus.pc_en),    32'd1);
        chk({tag, "_stall_cnt"}, bus.stall_cnt,    cnt_after);
      end
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    bus.pc_f = 32'h0000_3000;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    look();
    chk("rst_state",     32'(bus.state),   32'd0);
    chk("rst_stall_cnt", bus.stall_cnt,    32'd0);
    chk("rst_md_busy",   32'(bus.md_busy), 32'd0);

    // Sequential wrap
    step();
    bus.pc_f = 32'hFFFF_FFFC;
    look();
    chk("wrap_next_pc", bus.next_pc,     32'h0000_0000);
    chk("wrap_pc_en",   32'(bus.pc_en),  32'd1);
    step();
    look();
    chk("wrap_state",   32'(bus.state),  32'd0);
    bus.pc_f = 32'h0000_3008;

    // Mult then div stalls: 6 and 11 frozen cycles
    md_stall_run(1'b0, 6,  32'd6,  "mult");
    md_stall_run(1'b1, 11, 32'd17, "div");

    // Branch held under a load-use stall
    bus.br_taken_d = 1'b1; bus.br_target_d = 32'h0000_3100; bus.load_use_d = 1'b1;
    look();
    chk("brst_pc_en0",   32'(bus.pc_en),    32'd0);
    step();
    bus.load_use_d = 1'b0;
    look();
    chk("brst_next_pc",  bus.next_pc,       32'h0000_3100);
    chk("brst_pc_en1",   32'(bus.pc_en),    32'd1);
    chk("brst_flush_fd", 32'(bus.flush_fd), 32'd0);
    chk("brst_cnt",      bus.stall_cnt,     32'd18);
    step();
    idle();

    // ERET
    bus.eret_d = 1'b1; bus.epc = 32'h0000_3040;
    look();
    chk("eret_next_pc",  bus.next_pc,       32'h0000_3040);
    chk("eret_flush_fd", 32'(bus.flush_fd), 32'd1);
    chk("eret_pc_en",    32'(bus.pc_en),    32'd1);
    step();
    idle();

    // Exception beats everything
    bus.exc_req_m = 1'b1; bus.load_use_d = 1'b1; bus.md_start_e = 1'b1;
    bus.md_use_d = 1'b1; bus.br_taken_d = 1'b1; bus.br_target_d = 32'h0000_3200;
    look();
    chk("exc_next_pc",  bus.next_pc,       c_EXC);
    chk("exc_pc_en",    32'(bus.pc_en),    32'd1);
    chk("exc_flush_fd", 32'(bus.flush_fd), 32'd1);
    chk("exc_flush_de", 32'(bus.flush_de), 32'd1);
    chk("exc_flush_em", 32'(bus.flush_em), 32'd1);
    chk("exc_stall_fd", 32'(bus.stall_fd), 32'd0);
    step();
    idle();
    look();
    chk("exc_md_busy",  32'(bus.md_busy),  32'd0);
    chk("exc_state",    32'(bus.state),    32'd2);
    step();
    look();
    chk("exc_state_end", 32'(bus.state),   32'd0);

    // Reset three cycles after a divide start
    step();
    bus.md_start_e = 1'b1; bus.md_is_div_e = 1'b1;
    step();
    idle();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    look();
    chk("rstdiv_md_busy",   32'(bus.md_busy), 32'd0);
    chk("rstdiv_stall_cnt", bus.stall_cnt,    32'd0);
    chk("rstdiv_state",     32'(bus.state),   32'd0);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      step();
      reset           = ($urandom_range(0, 299) == 0);
      bus.pc_f        = {$urandom} & 32'hFFFF_FFFC;
      bus.load_use_d  = ($urandom_range(0, 5) == 0);
      bus.md_use_d    = ($urandom_range(0, 2) == 0);
      bus.md_start_e  = ($urandom_range(0, 7) == 0);
      bus.md_is_div_e = $urandom_range(0, 1) == 1;
      bus.br_taken_d  = ($urandom_range(0, 4) == 0);
      bus.br_target_d = $urandom;
      bus.eret_d      = ($urandom_range(0, 9) == 0);
      bus.epc         = $urandom;
      bus.exc_req_m   = ($urandom_range(0, 19) == 0);
    end
    step();
    reset = 1'b0;
    idle();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
